// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA generator and the receive-side
// monitor, plus the monitor's lock FSM encoding.
package vga_timing_pkg;

    localparam int H_TOTAL    = 1600;
    localparam int H_SYNC     = 192;
    localparam int H_BACK     = 96;
    localparam int H_ACTIVE   = 1280;
    localparam int V_TOTAL    = 525;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam int V_ACTIVE   = 480;
    localparam int LOCK_LINES = 4;

    localparam int H_CNT_W = 11;
    localparam int V_CNT_W = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous sync input, followed by registered
// single-cycle fall/rise pulses (3 cycles after the input edge).
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic fall_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sync flops reset to the idle-high level so reset release never fakes an edge.
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= prev_q & ~sync_q;
            rise_q <= ~prev_q & sync_q;
        end
    end

    assign fall_o = fall_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: locks to incoming hsync/vsync, recovers pixel
// coordinates and a video-active flag, and flags line/frame timing violations.
module vga_sync_monitor #(
    parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BACK     = vga_timing_pkg::H_BACK,
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int V_TOTAL    = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BACK     = vga_timing_pkg::V_BACK,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int LOCK_LINES = vga_timing_pkg::LOCK_LINES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       locked,
    output logic       frame_valid,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err
);

    import vga_timing_pkg::lock_state_t;
    import vga_timing_pkg::SEARCH;
    import vga_timing_pkg::VERIFY;
    import vga_timing_pkg::LOCKED;

    localparam logic [10:0] H_CNT_MAX   = '1;
    localparam logic [9:0]  V_CNT_MAX   = '1;
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC - 1);
    localparam logic [10:0] H_LINE_END  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_FRAME_END = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_ACT_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [2:0]  GOOD_LAST   = 3'(LOCK_LINES - 1);

    logic hs_fall;
    logic hs_rise;
    logic vs_fall;
    logic vs_rise_unused;

    sync_edge_detect u_hsync (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .d_i    (hsync_in),
        .fall_o (hs_fall),
        .rise_o (hs_rise)
    );

    sync_edge_detect u_vsync (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .d_i    (vsync_in),
        .fall_o (vs_fall),
        .rise_o (vs_rise_unused)
    );

    lock_state_t state_q;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [2:0]  good_cnt_q;
    logic        width_ok_q;
    logic        locked_q;
    logic        frame_valid_q;
    logic        v_seen_q;
    logic        frame_start_q;
    logic        h_err_q;
    logic        v_err_q;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;

    logic h_timeout;
    logic period_ok;
    logic h_active;
    logic v_active;

    assign h_timeout = (h_cnt_q == H_CNT_MAX);
    assign period_ok = (h_cnt_q == H_LINE_END) && width_ok_q;

    always_comb begin
        h_cnt_d = h_cnt_q;
        if (hs_fall) begin
            h_cnt_d = '0;
        end else if (!h_timeout) begin
            h_cnt_d = h_cnt_q + 11'd1;
        end

        v_cnt_d = v_cnt_q;
        if (vs_fall) begin
            v_cnt_d = '0;
        end else if (hs_fall && (v_cnt_q != V_CNT_MAX)) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end

        h_active   = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
        v_active   = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
        video_on_d = locked_q && frame_valid_q && h_active && v_active;
        pixel_x_d  = '0;
        pixel_y_d  = '0;
        if (video_on_d) begin
            pixel_x_d = 10'((h_cnt_q - H_ACT_START) >> 1);
            pixel_y_d = 10'({1'b0, v_cnt_q} - {1'b0, V_ACT_START});
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= SEARCH;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            good_cnt_q    <= '0;
            width_ok_q    <= 1'b0;
            locked_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            v_seen_q      <= 1'b0;
            frame_start_q <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= vs_fall;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;

            if (hs_rise) begin
                width_ok_q <= (h_cnt_q == H_SYNC_END);
            end

            // Frame-length check only counts once a previous vsync was seen under lock.
            if (vs_fall && locked_q) begin
                v_seen_q <= 1'b1;
                if (v_seen_q) begin
                    if (v_cnt_q == V_FRAME_END) begin
                        frame_valid_q <= 1'b1;
                    end else begin
                        frame_valid_q <= 1'b0;
                        v_err_q       <= 1'b1;
                    end
                end
            end

            // NOTE: the last non-blocking assignment wins, so loss of lock below overrides the frame update above.
            case (state_q)
                SEARCH: begin
                    if (hs_fall) begin
                        state_q    <= VERIFY;
                        good_cnt_q <= '0;
                    end
                end
                VERIFY: begin
                    if (hs_fall) begin
                        if (!period_ok) begin
                            good_cnt_q <= '0;
                        end else if (good_cnt_q == GOOD_LAST) begin
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                            good_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 3'd1;
                        end
                    end else if (h_timeout) begin
                        state_q <= SEARCH;
                    end
                end
                LOCKED: begin
                    if ((hs_fall && !period_ok) || (!hs_fall && h_timeout)) begin
                        state_q       <= SEARCH;
                        h_err_q       <= 1'b1;
                        locked_q      <= 1'b0;
                        frame_valid_q <= 1'b0;
                        v_seen_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign locked      = locked_q;
    assign frame_valid = frame_valid_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor on a scaled-down raster, compared every
// cycle against a behavioural timing model plus hand-computed spot values.
module tb_vga_sync_monitor;

    localparam int HT = 64;
    localparam int HS = 8;
    localparam int HB = 8;
    localparam int HA = 40;
    localparam int VT = 12;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VA = 6;
    localparam int LL = 4;
    localparam int H_SAT = 2047;
    localparam int V_SAT = 1023;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       locked, frame_valid, video_on, frame_start, h_err, v_err;
    logic [9:0] pixel_x, pixel_y;

    int n_checks = 0;
    int n_pass   = 0;
    int herr_cnt = 0;
    int verr_cnt = 0;
    bit cap_en   = 1'b0;
    bit cap_any  = 1'b0;
    int first_x, first_y, last_x, last_y;

    always #5 Clk = ~Clk;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
        .LOCK_LINES(LL)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .locked      (locked),
        .frame_valid (frame_valid),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start),
        .h_err       (h_err),
        .v_err       (v_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: events reach the monitor 3 cycles after the pin edge,
    // and registered outputs follow the event by one more cycle.
    bit hs_h[4];
    bit vs_h[4];
    bit m_ready = 1'b0;
    int pos, line, good;
    bit wgood, tracking, m_locked, m_fv, seen;
    bit e_locked, e_fv, e_von, e_fs, e_herr, e_verr;
    int e_px, e_py;

    always @(posedge Clk) begin : model
        bit hf, hr, vf, pgood, tmo;
        hf = hs_h[3] && !hs_h[2];
        hr = !hs_h[3] && hs_h[2];
        vf = vs_h[3] && !vs_h[2];
        if (Reset) begin
            pos = 0; line = 0; good = 0;
            wgood = 0; tracking = 0; m_locked = 0; m_fv = 0; seen = 0;
            e_locked = 0; e_fv = 0; e_von = 0; e_fs = 0; e_herr = 0; e_verr = 0;
            e_px = 0; e_py = 0;
            for (int i = 0; i < 4; i++) begin
                hs_h[i] = 1'b1;
                vs_h[i] = 1'b1;
            end
            m_ready = 1'b1;
        end else begin
            e_von = m_locked && m_fv && pos >= HS + HB && pos < HS + HB + HA
                    && line >= VS + VB && line < VS + VB + VA;
            e_px  = e_von ? (pos - HS - HB) / 2 : 0;
            e_py  = e_von ? line - VS - VB : 0;
            e_fs  = vf;
            pgood = hf && pos == HT - 1 && wgood;
            tmo   = pos == H_SAT;
            e_herr = m_locked && (hf ? !pgood : tmo);
            e_verr = vf && m_locked && seen && line != VT - 1;
            if (vf && m_locked) begin
                if (seen) m_fv = (line == VT - 1);
                seen = 1'b1;
            end
            if (m_locked) begin
                if (e_herr) begin
                    m_locked = 0; tracking = 0; m_fv = 0; seen = 0;
                end
            end else if (!tracking) begin
                if (hf) begin
                    tracking = 1; good = 0;
                end
            end else if (hf) begin
                good = pgood ? good + 1 : 0;
                if (good == LL) begin
                    m_locked = 1; tracking = 0; good = 0;
                end
            end else if (tmo) begin
                tracking = 0;
            end
            if (hr) wgood = (pos == HS - 1);
            pos  = hf ? 0 : (pos < H_SAT ? pos + 1 : H_SAT);
            line = vf ? 0 : ((hf && line < V_SAT) ? line + 1 : line);
            e_locked = m_locked;
            e_fv     = m_fv;
            for (int i = 3; i > 0; i--) begin
                hs_h[i] = hs_h[i - 1];
                vs_h[i] = vs_h[i - 1];
            end
            hs_h[0] = hsync_in;
            vs_h[0] = vsync_in;
        end
    end

    always @(negedge Clk) begin
        if (m_ready) begin
            check("outputs_vs_model",
                  {6'd0, locked, frame_valid, video_on, pixel_x, pixel_y, frame_start, h_err, v_err},
                  {6'd0, e_locked, e_fv, e_von, 10'(e_px), 10'(e_py), e_fs, e_herr, e_verr});
            if (h_err === 1'b1) herr_cnt++;
            if (v_err === 1'b1) verr_cnt++;
            if (cap_en && video_on === 1'b1) begin
                if (!cap_any) begin
                    first_x = int'(pixel_x);
                    first_y = int'(pixel_y);
                    cap_any = 1'b1;
                end
                last_x = int'(pixel_x);
                last_y = int'(pixel_y);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_line(input int len, input int w, input bit v_low);
        hsync_in = 1'b0;
        vsync_in = !v_low;
        repeat (w) tick();
        hsync_in = 1'b1;
        repeat (len - w) tick();
    endtask

    task automatic send_frame(input int n_lines, input int short_line, input int narrow_line);
        for (int l = 0; l < n_lines; l++)
            send_line((l == short_line) ? HT - 2 : HT, (l == narrow_line) ? HS - 2 : HS, l < VS);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {6'd0, locked, frame_valid, video_on, pixel_x, pixel_y, frame_start, h_err, v_err}, 0);
    endtask

    initial begin
        int h0, v0;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        Reset = 1'b0;
        repeat (5) tick();
        check_all_zero("idle_outputs");

        // Frame A: lock on the 5th hsync fall (line 4 starts 4*HT cycles in).
        fork
            send_frame(VT, -1, -1);
            begin
                repeat (4 * HT + 3) tick();
                check("lock_before_5th_fall", locked, 0);
                tick();
                check("lock_at_5th_fall", locked, 1);
            end
        join
        send_frame(VT, -1, -1);
        check("fv_after_first_locked_vsync", frame_valid, 0);

        // Frame C: second locked vsync validates the frame; capture the raster extent.
        cap_en = 1'b1;
        fork
            send_frame(VT, -1, -1);
            begin
                repeat (3) tick();
                check("fv_before_second_vsync", frame_valid, 0);
                tick();
                check("fv_at_second_vsync", frame_valid, 1);
            end
        join
        cap_en = 1'b0;
        check("video_seen", cap_any, 1);
        check("first_pixel_x", first_x, 0);
        check("first_pixel_y", first_y, 0);
        check("last_pixel_x", last_x, HA / 2 - 1);
        check("last_pixel_y", last_y, VA - 1);

        // Short line at line 6.
        h0 = herr_cnt;
        send_frame(VT, 6, -1);
        check("short_line_herr_pulses", herr_cnt - h0, 1);
        check("short_line_unlocked", locked, 0);
        check("short_line_fv_cleared", frame_valid, 0);

        // Narrow hsync at line 3, relock by line 9.
        h0 = herr_cnt;
        send_frame(VT, -1, 3);
        check("narrow_sync_herr_pulses", herr_cnt - h0, 1);
        check("narrow_sync_relocked", locked, 1);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        check("fv_restored", frame_valid, 1);

        // Short frame, then a correct one.
        v0 = verr_cnt;
        send_frame(VT - 1, -1, -1);
        send_frame(VT, -1, -1);
        check("short_frame_verr_pulses", verr_cnt - v0, 1);
        check("short_frame_fv_cleared", frame_valid, 0);
        send_frame(VT, -1, -1);
        check("good_frame_no_verr", verr_cnt - v0, 1);
        check("good_frame_fv_set", frame_valid, 1);

        // hsync stuck high: counter saturates, a single h_err.
        h0 = herr_cnt;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (2300) tick();
        check("timeout_herr_pulses", herr_cnt - h0, 1);
        check("timeout_unlocked", locked, 0);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        check("post_timeout_fv", frame_valid, 1);

        // Reset in the middle of active line 5 (row 1), then relock.
        for (int l = 0; l < 5; l++) send_line(HT, HS, l < VS);
        fork
            send_line(HT, HS, 1'b0);
            begin
                repeat (29) tick();
                check("midline_video_on", video_on, 1);
                check("midline_pixel_x", pixel_x, 4);
                check("midline_pixel_y", pixel_y, 1);
                Reset = 1'b1;
                tick();
                check_all_zero("midline_reset_outputs");
                Reset = 1'b0;
            end
        join
        for (int l = 0; l < 4; l++) send_line(HT, HS, 1'b0);
        check("relock_not_before_5th_fall", locked, 0);
        send_line(HT, HS, 1'b0);
        check("relock_at_5th_fall", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator. It samples an incoming hsync/vsync pair, measures line and frame timing, and locks to the 640x480@60 format.
- In that format one line is 1600 Clk cycles and one pixel is 2 Clk cycles.
- Once locked, it recovers pixel coordinates and a video-active flag for downstream capture or checking logic.
- It reports timing violations as single-cycle error pulses.

Parameters:
- H_TOTAL, 1600, Clk cycles per line
- H_SYNC, 192, hsync low width in Clk cycles
- H_BACK, 96, back porch in Clk cycles
- H_ACTIVE, 1280, active region in Clk cycles (640 px x 2)
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync low width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, active lines
- LOCK_LINES, 4, consecutive good lines required for lock

Ports:
- Clk, input, 1, system clock
- Reset, input, 1, synchronous, active-high
- hsync_in, input, 1, horizontal sync, active low, asynchronous to Clk
- vsync_in, input, 1, vertical sync, active low, asynchronous to Clk
- locked, output, 1, horizontal timing locked
- frame_valid, output, 1, at least one correct-length frame seen while locked
- video_on, output, 1, current pixel in active area
- pixel_x, output, 10, active column 0..639
- pixel_y, output, 10, active row 0..479
- frame_start, output, 1, one-cycle pulse on each synchronized vsync falling edge
- h_err, output, 1, one-cycle horizontal violation pulse
- v_err, output, 1, one-cycle vertical violation pulse

Behaviour:
- Reset: every output is 0, FSM is SEARCH, all counters are 0. Synchronizer flops reset to 1 (sync idle high).
- Reset asserted mid-frame clears everything within the same edge. Lock is re-acquired from scratch.
- Input capture: 2-flop synchronizer, then one edge-detect register.
  - hs_fall / hs_rise / vs_fall are asserted 3 Clk cycles after the input edge.
- h_cnt (11 bit):
  - Loads 0 in the cycle hs_fall is asserted.
  - Otherwise increments.
  - Saturates at 2047; saturation is a timeout.
- Width check: at hs_rise, width_ok <= (h_cnt == H_SYNC-1).
- Period check: at hs_fall, period_ok = (h_cnt == H_TOTAL-1) && width_ok.
- Lock FSM:
  - SEARCH: on the first hs_fall go to VERIFY, good_cnt=0.
  - VERIFY: on each hs_fall, if period_ok then good_cnt++, else good_cnt=0.
    - When good_cnt reaches LOCK_LINES, go to LOCKED and set locked=1.
  - LOCKED: on hs_fall with !period_ok, or on h_cnt timeout, pulse h_err, go to SEARCH, and clear locked and frame_valid.
  - Timeout in VERIFY also returns to SEARCH, without h_err.
- v_cnt (10 bit):
  - Loads 0 on vs_fall.
  - Otherwise increments on hs_fall.
  - vs_fall has priority when coincident with hs_fall.
  - Saturates at 1023.
- At vs_fall while locked:
  - If v_seen && v_cnt == V_TOTAL-1, set frame_valid.
  - If v_seen && mismatch, pulse v_err and clear frame_valid.
  - Always set v_seen.
- v_seen clears whenever locked clears.
- frame_start pulses on every vs_fall, regardless of lock.
- Coordinates are registered, 1-cycle latency after h_cnt/v_cnt.
  - video_on = locked && frame_valid && h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) && v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
  - pixel_x = (h_cnt-288)>>1 and pixel_y = v_cnt-35 when video_on; both hold 0 otherwise.
- Width rules: subtractions are done in 11 bits and truncated to 10.

Decomposition:
- Shared package vga_timing_pkg holds all H_*/V_* constants (shared with the generator side) and the FSM state encoding (SEARCH=0, VERIFY=1, LOCKED=2).
- One sub-module, sync_edge_detect: 2-flop synchronizer plus fall/rise pulses, instantiated twice.

Test Plan:
- Nominal stream from the generator: hs_fall #1 enters VERIFY; locked=1 at hs_fall #5. After the second vsync, frame_valid=1. First video_on cycle has pixel_x=0, pixel_y=0 at h_cnt=288, v_cnt=35. Last cycle has pixel_x=639, pixel_y=479.
- Locked, one line of 1598 cycles: h_err pulses once at that hs_fall; locked=0, frame_valid=0, video_on=0. Re-lock after 4 further good lines.
- Locked, hsync width 190 with correct period: h_err at the next hs_fall, back to SEARCH.
- Locked and frame_valid, one frame of 524 lines: v_err pulses at vs_fall, frame_valid=0. Next 525-line frame sets frame_valid=1 again, with no v_err.
- hsync held high after lock: h_cnt saturates at 2047, h_err pulses once, locked=0, no further pulses.
- Reset asserted for 1 cycle mid-active-line: next cycle all outputs are 0 and FSM is SEARCH. Lock returns 5 hs_fall events later.
